mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the instruction-fetch port, the data port,
// the shared single-port memory and the arbiter.
interface mem_arbiter_if;
  // Instruction-fetch port
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;

  // Data port
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;

  // Shared memory side
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;

  // Status
  logic        busy;
  logic        err;

  // Arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    output i_done, i_rdata, d_done, d_rdata,
           mem_en, mem_wr, mem_addr, mem_wdata, busy, err
  );

  // Requester / memory model view
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    input  i_done, i_rdata, d_done, d_rdata,
           mem_en, mem_wr, mem_addr, mem_wdata, busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a shared single-port memory. Data accesses
// normally win, but a fetch that has been passed over STARVE_MAX times in a
// row gets the next grant. One transaction is in flight at a time.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; grant on a pending request
// ISSUE | mem_en strobe for one cycle with latched addr/wr/wdata
// WAIT  | waiting for mem_valid, abort after TIMEOUT cycles
// DONE  | done pulse to the owner (plus err on abort), back to IDLE
module mem_arbiter #(
  parameter logic [7:0] TIMEOUT    = 8'd255,
  parameter logic [1:0] STARVE_MAX = 2'd2
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q,    state_d;
  logic        owner_q,    owner_d;    // 1 = data port, 0 = fetch port
  logic        wr_q,       wr_d;
  logic [15:0] addr_q,     addr_d;
  logic [15:0] wdata_q,    wdata_d;
  logic [1:0]  starve_q,   starve_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        err_q,      err_d;
  logic [15:0] i_rdata_q,  i_rdata_d;
  logic [15:0] d_rdata_q,  d_rdata_d;

  logic        grant_d_port;
  logic        grant_i_port;

  // State and datapath registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      starve_q   <= 2'd0;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
      i_rdata_q  <= 16'h0000;
      d_rdata_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Grant decision, transaction sequencing and read-data capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_d     = starve_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_d_port = 1'b0;
    grant_i_port = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant_d_port = bus.d_req && !(bus.i_req && (starve_q == STARVE_MAX));
        grant_i_port = bus.i_req && !grant_d_port;
        if (grant_d_port) begin
          owner_d  = 1'b1;
          wr_d     = bus.d_wr;
          addr_d   = bus.d_addr;
          wdata_d  = bus.d_wdata;
          err_d    = 1'b0;
          state_d  = S_ISSUE;
          // Only count D grants that actually pass over a waiting fetch.
          if (bus.i_req)
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 2'd1;
          else
            starve_d = 2'd0;
        end else if (grant_i_port) begin
          owner_d  = 1'b0;
          wr_d     = 1'b0;
          addr_d   = bus.i_addr;
          wdata_d  = 16'h0000;
          err_d    = 1'b0;
          starve_d = 2'd0;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wait_cnt_d = 8'd0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        // mem_valid has priority over the timeout on the same edge.
        if (bus.mem_valid) begin
          if (!wr_q) begin
            if (owner_q) d_rdata_d = bus.mem_rdata;
            else         i_rdata_d = bus.mem_rdata;
          end
          state_d = S_DONE;
        end else if (wait_cnt_q == TIMEOUT - 8'd1) begin
          // Last permitted WAIT cycle expired: abort with zeroed read data.
          if (!wr_q) begin
            if (owner_q) d_rdata_d = 16'h0000;
            else         i_rdata_d = 16'h0000;
          end
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state.
  assign bus.mem_en    = (state_q == S_ISSUE);
  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.i_done    = (state_q == S_DONE) && !owner_q;
  assign bus.d_done    = (state_q == S_DONE) &&  owner_q;
  assign bus.err       = (state_q == S_DONE) &&  err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule
